// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC and issues one outstanding fetch at a time.
// It presents each fetched instruction to the decoder through a valid/ready output register.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned INST_W   = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              imem_rsp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  output logic              inst_fault,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic              halt
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT, S_HALT} state_t;

  state_t              state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic                drop_q, drop_d;
  logic                halted_q, halted_d;
  logic                inst_valid_q, inst_valid_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [XLEN-1:0]     inst_pc_q, inst_pc_d;
  logic                inst_fault_q, inst_fault_d;
  logic                aligned;
  logic                kill;

  assign aligned        = (pc_q[1:0] == 2'b00);
  // Gated by rst_n so no request is presented while reset is held.
  assign imem_req_valid = rst_n && (state_q == S_REQ) && aligned;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign inst_fault     = inst_fault_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    halted_d     = halted_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;
    kill         = 1'b0;

    case (state_q)
      S_REQ: begin
        if (halt) halted_d = 1'b1;
        if (redirect_valid) pc_d = redirect_pc;
        if (halt || redirect_valid) begin
          // A request accepted this cycle is stale; its response must be absorbed.
          if (aligned && imem_req_ready) begin
            state_d = S_WAIT;
            drop_d  = 1'b1;
          end else begin
            state_d = halt ? S_HALT : S_REQ;
          end
        end else if (!aligned) begin
          inst_d       = NOP_INST[INST_W-1:0];
          inst_pc_d    = pc_q;
          inst_fault_d = 1'b1;
          inst_valid_d = 1'b1;
          state_d      = S_OUT;
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (halt) halted_d = 1'b1;
        if (redirect_valid) pc_d = redirect_pc;
        kill = halt || redirect_valid || drop_q;
        if (imem_rsp_valid) begin
          drop_d = 1'b0;
          if (kill) begin
            state_d = halted_d ? S_HALT : S_REQ;
          end else begin
            inst_d       = imem_rsp_err ? NOP_INST[INST_W-1:0] : imem_rsp_data;
            inst_pc_d    = pc_q;
            inst_fault_d = imem_rsp_err;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + XLEN'(4);
            state_d      = S_OUT;
          end
        end else if (halt || redirect_valid) begin
          drop_d = 1'b1;
        end
      end

      S_OUT: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (halt) begin
          halted_d     = 1'b1;
          inst_valid_d = 1'b0;
          state_d      = S_HALT;
        end else if (redirect_valid || inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = S_REQ;
        end
      end

      default: begin
        inst_valid_d = 1'b0;
        state_d      = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC[XLEN-1:0];
      drop_q       <= 1'b0;
      halted_q     <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      halted_q     <= halted_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: the bench plays instruction memory and decoder cycle by cycle.
// It also runs hand sequences for PC wrap, asynchronous reset and halt-vs-redirect.
module tb_ifu_fetch;

  localparam logic [31:0] A = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;

  int total = 0;
  int bad   = 0;

  ifu_fetch #(
    .RESET_PC(32'h8000_0000),
    .XLEN(32),
    .INST_W(32),
    .NOP_INST(32'h0000_0013)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_fault(inst_fault),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halt(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rspv;
    logic [31:0] rspd;
    logic        rspe;
    logic        irdy;
    logic        rdv;
    logic [31:0] rdpc;
    logic        hlt;
    logic        e_reqv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
    logic        e_f;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rdy, input logic rspv, input logic [31:0] rspd,
                              input logic rspe, input logic irdy, input logic rdv,
                              input logic [31:0] rdpc, input logic hlt,
                              input logic e_reqv, input logic [31:0] e_addr, input logic e_iv,
                              input logic [31:0] e_inst, input logic [31:0] e_ipc, input logic e_f);
    vec_t v;
    v.rdy = rdy; v.rspv = rspv; v.rspd = rspd; v.rspe = rspe; v.irdy = irdy;
    v.rdv = rdv; v.rdpc = rdpc; v.hlt = hlt;
    v.e_reqv = e_reqv; v.e_addr = e_addr; v.e_iv = e_iv;
    v.e_inst = e_inst; v.e_ipc = e_ipc; v.e_f = e_f;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rspv, input logic [31:0] rspd,
                       input logic rspe, input logic irdy, input logic rdv,
                       input logic [31:0] rdpc, input logic hlt);
    imem_req_ready = rdy;
    imem_rsp_valid = rspv;
    imem_rsp_data  = rspd;
    imem_rsp_err   = rspe;
    inst_ready     = irdy;
    redirect_valid = rdv;
    redirect_pc    = rdpc;
    halt           = hlt;
  endtask

  task automatic chk_all(input string tag, input logic reqv, input logic [31:0] addr,
                         input logic iv, input logic [31:0] ins, input logic [31:0] ipc,
                         input logic f);
    chk({tag, " req_valid"}, 32'(imem_req_valid), 32'(reqv));
    chk({tag, " req_addr"},  imem_req_addr, addr);
    chk({tag, " inst_valid"}, 32'(inst_valid), 32'(iv));
    chk({tag, " inst"},      inst, ins);
    chk({tag, " inst_pc"},   inst_pc, ipc);
    chk({tag, " inst_fault"}, 32'(inst_fault), 32'(f));
  endtask

  initial begin
    // rdy rspv rspd rspe irdy rdv rdpc hlt | reqv addr iv inst ipc f
    vq.push_back(mk(1,0,0,0,0,0,0,0, 1,A,     0,0,0,0));
    vq.push_back(mk(0,1,32'h0010_0093,0,0,0,0,0, 0,A, 0,0,0,0));
    for (int k = 0; k < 5; k++)
      vq.push_back(mk(0,0,0,0,0,0,0,0, 0,A+4, 1,32'h0010_0093,A,0));
    vq.push_back(mk(0,0,0,0,1,0,0,0, 0,A+4, 1,32'h0010_0093,A,0));
    vq.push_back(mk(1,0,0,0,0,0,0,0, 1,A+4, 0,32'h0010_0093,A,0));
    vq.push_back(mk(0,1,32'h0000_0073,0,0,0,0,0, 0,A+4, 0,32'h0010_0093,A,0));
    vq.push_back(mk(0,0,0,0,1,0,0,0, 0,A+8, 1,32'h0000_0073,A+4,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0, 1,A+8, 0,32'h0000_0073,A+4,0));
    vq.push_back(mk(1,0,0,0,0,0,0,0, 1,A+8, 0,32'h0000_0073,A+4,0));
    vq.push_back(mk(0,0,0,0,0,1,A+32'h100,0, 0,A+8, 0,32'h0000_0073,A+4,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0, 0,A+32'h100, 0,32'h0000_0073,A+4,0));
    vq.push_back(mk(0,1,32'hDEAD_BEEF,0,0,0,0,0, 0,A+32'h100, 0,32'h0000_0073,A+4,0));
    vq.push_back(mk(1,0,0,0,0,1,A+32'h200,0, 1,A+32'h100, 0,32'h0000_0073,A+4,0));
    vq.push_back(mk(0,1,32'h1111_1111,0,0,0,0,0, 0,A+32'h200, 0,32'h0000_0073,A+4,0));
    vq.push_back(mk(1,0,0,0,0,0,0,0, 1,A+32'h200, 0,32'h0000_0073,A+4,0));
    vq.push_back(mk(0,1,32'h0020_0113,0,0,0,0,0, 0,A+32'h200, 0,32'h0000_0073,A+4,0));
    vq.push_back(mk(0,0,0,0,0,1,A+32'h102,0, 0,A+32'h204, 1,32'h0020_0113,A+32'h200,0));
    vq.push_back(mk(1,0,0,0,0,0,0,0, 0,A+32'h102, 0,32'h0020_0113,A+32'h200,0));
    vq.push_back(mk(0,0,0,0,1,1,A+32'h300,0, 0,A+32'h102, 1,32'h0000_0013,A+32'h102,1));
    vq.push_back(mk(1,0,0,0,0,0,0,0, 1,A+32'h300, 0,32'h0000_0013,A+32'h102,1));
    vq.push_back(mk(0,1,32'h1234_5678,1,0,0,0,0, 0,A+32'h300, 0,32'h0000_0013,A+32'h102,1));
    vq.push_back(mk(0,0,0,0,1,0,0,0, 0,A+32'h304, 1,32'h0000_0013,A+32'h300,1));
    vq.push_back(mk(1,0,0,0,0,0,0,0, 1,A+32'h304, 0,32'h0000_0013,A+32'h300,1));
    vq.push_back(mk(0,0,0,0,0,0,0,1, 0,A+32'h304, 0,32'h0000_0013,A+32'h300,1));
    vq.push_back(mk(0,1,32'hAAAA_AAAA,0,0,0,0,0, 0,A+32'h304, 0,32'h0000_0013,A+32'h300,1));
    vq.push_back(mk(1,0,0,0,0,0,0,0, 0,A+32'h304, 0,32'h0000_0013,A+32'h300,1));
    vq.push_back(mk(1,0,0,0,1,0,0,0, 0,A+32'h304, 0,32'h0000_0013,A+32'h300,1));
    vq.push_back(mk(1,0,0,0,1,0,0,0, 0,A+32'h304, 0,32'h0000_0013,A+32'h300,1));

    rst_n = 1'b0;
    drive(0,0,0,0,0,0,0,0);
    @(negedge clk);
    #1;
    chk_all("reset", 0, A, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rdy, vq[i].rspv, vq[i].rspd, vq[i].rspe,
            vq[i].irdy, vq[i].rdv, vq[i].rdpc, vq[i].hlt);
      #1;
      chk_all($sformatf("v%0d", i), vq[i].e_reqv, vq[i].e_addr, vq[i].e_iv,
              vq[i].e_inst, vq[i].e_ipc, vq[i].e_f);
      @(negedge clk);
    end

    // Reset clears a halted unit, then PC wrap at the top of the address space.
    rst_n = 1'b0;
    drive(0,0,0,0,0,0,0,0);
    #1;
    chk_all("rst2", 0, A, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0,0,0,0,0,1,32'hFFFF_FFFC,0);
    #1;
    chk("wrap0 req_valid", 32'(imem_req_valid), 32'd1);
    @(negedge clk);
    drive(1,0,0,0,0,0,0,0);
    #1;
    chk("wrap1 req_addr", imem_req_addr, 32'hFFFF_FFFC);
    chk("wrap1 req_valid", 32'(imem_req_valid), 32'd1);
    @(negedge clk);
    drive(0,1,32'h0000_0001,0,0,0,0,0);
    #1;
    chk("wrap2 req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    drive(0,0,0,0,0,0,0,0);
    #1;
    chk_all("wrap3", 0, 32'h0000_0000, 1, 32'h0000_0001, 32'hFFFF_FFFC, 0);

    // Asynchronous reset in the middle of the low clock phase while an instruction is held.
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, A, 0, 0, 0, 0);

    // Halt together with a redirect: halt wins, pc still takes the target.
    @(negedge clk);
    rst_n = 1'b1;
    drive(0,0,0,0,0,1,A+32'h40,1);
    #1;
    chk("hr0 req_valid", 32'(imem_req_valid), 32'd1);
    @(negedge clk);
    drive(1,0,0,0,1,0,0,0);
    #1;
    chk_all("hr1", 0, A+32'h40, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk_all("hr2", 0, A+32'h40, 0, 0, 0, 0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
